// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte FIFO feeding an LSB-first serialiser.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with ODD_PARITY=1).
module uart_tx_fifo #(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned BAUD       = 115_200,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned AW         = 4
`ifdef UART_TX_PARITY_EN
   ,
   parameter bit          ODD_PARITY = 1'b0
`endif
) (
   input  logic          clk_s,
   input  logic          rst_s,
   input  logic [7:0]    iDATA,
   input  logic          iVALID,
   output logic          oREADY,
   output logic          oTXDATA,
   output logic          oBUSY,
   output logic          oFINISH,
   output logic [AW:0]   oLEVEL
);

   localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int unsigned CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } txState_t;

   txState_t state, stateNext;

   logic [7:0]    fifoMem [FIFO_DEPTH];
   logic [AW-1:0] wrPtr, rdPtr;
   logic [AW:0]   count;
   logic          push, pop;
   logic          fifoNotEmpty;

   logic [CW-1:0] baudCnt;
   logic          baudLast;
   logic [2:0]    bitIdx;
   logic [7:0]    shiftReg;
   logic          txNext;
`ifdef UART_TX_PARITY_EN
   logic          parityBit;
`endif

   assign fifoNotEmpty = (count != '0);
   assign oREADY       = (count != FULL_LEVEL);
   assign oLEVEL       = count;
   assign push         = iVALID && oREADY;
   assign baudLast     = (baudCnt == BAUD_LAST);

   // State register
   always_ff @(posedge clk_s) begin
      if (rst_s) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (fifoNotEmpty) stateNext = START;
         end
         START: begin
            if (baudLast) stateNext = DATA;
         end
         DATA: begin
            if (baudLast && (bitIdx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
               stateNext = PARITY;
`else
               stateNext = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baudLast) stateNext = STOP;
         end
`endif
         STOP: begin
            if (baudLast) stateNext = fifoNotEmpty ? START : IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Output logic; the line value is registered one cycle behind the state
   always_comb begin
      oBUSY   = (state != IDLE);
      oFINISH = (state == STOP) && baudLast;
      pop     = fifoNotEmpty && ((state == IDLE) || ((state == STOP) && baudLast));
      txNext  = 1'b1;
      case (state)
         IDLE:   txNext = 1'b1;
         START:  txNext = 1'b0;
         DATA:   txNext = shiftReg[0];
`ifdef UART_TX_PARITY_EN
         PARITY: txNext = parityBit;
`endif
         STOP:   txNext = 1'b1;
         default: txNext = 1'b1;
      endcase
   end

   always_ff @(posedge clk_s) begin
      if (push) fifoMem[wrPtr] <= iDATA;
   end

   always_ff @(posedge clk_s) begin
      if (rst_s) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         count    <= '0;
         baudCnt  <= '0;
         bitIdx   <= '0;
         shiftReg <= '0;
         oTXDATA  <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parityBit <= 1'b0;
`endif
      end else begin
         oTXDATA <= txNext;

         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         // Pop only happens in IDLE or on the last STOP clock, so it never races a DATA shift
         if (pop) begin
            shiftReg <= fifoMem[rdPtr];
`ifdef UART_TX_PARITY_EN
            parityBit <= (^fifoMem[rdPtr]) ^ ODD_PARITY;
`endif
         end else if ((state == DATA) && baudLast) begin
            shiftReg <= {1'b0, shiftReg[7:1]};
         end

         if (state == START) begin
            bitIdx <= '0;
         end else if ((state == DATA) && baudLast) begin
            bitIdx <= bitIdx + 1'b1;
         end

         if ((state == IDLE) || baudLast) begin
            baudCnt <= '0;
         end else begin
            baudCnt <= baudCnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at default parameters (434 clocks per bit).
// Builds with or without UART_TX_PARITY_EN; a background decoder recovers transmitted bytes.
module tb_uart_tx_fifo;

   localparam int unsigned CPB = 434;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned NBITS = 11;
`else
   localparam int unsigned NBITS = 10;
`endif
   localparam int unsigned FRAME = NBITS * CPB;

   logic       clk_s = 1'b0;
   logic       rst_s = 1'b1;
   logic [7:0] iDATA = '0;
   logic       iVALID = 1'b0;
   logic       oREADY, oTXDATA, oBUSY, oFINISH;
   logic [4:0] oLEVEL;

   int unsigned nChecks = 0;
   int unsigned nErrors = 0;
   int unsigned cyc = 0;
   int          frameErrs = 0;
   logic [7:0]  rxQ[$];
   int unsigned rxStart[$];

   uart_tx_fifo dut (
      .clk_s  (clk_s),
      .rst_s  (rst_s),
      .iDATA  (iDATA),
      .iVALID (iVALID),
      .oREADY (oREADY),
      .oTXDATA(oTXDATA),
      .oBUSY  (oBUSY),
      .oFINISH(oFINISH),
      .oLEVEL (oLEVEL)
   );

   always #10 clk_s = ~clk_s;
   always @(posedge clk_s) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Line decoder: samples mid-bit, records byte and the cycle its start bit appeared
   initial begin
      logic [7:0]  b;
      int unsigned st;
      bit          ok;
      forever begin
         @(negedge clk_s);
         if (!rst_s && oTXDATA === 1'b0) begin
            st = cyc;
            ok = 1'b1;
            b  = '0;
            repeat (CPB / 2) @(negedge clk_s);
            if (oTXDATA !== 1'b0) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk_s);
               b[i] = oTXDATA;
            end
`ifdef UART_TX_PARITY_EN
            repeat (CPB) @(negedge clk_s);
            if (oTXDATA !== ^b) ok = 1'b0;
`endif
            repeat (CPB) @(negedge clk_s);
            if (oTXDATA !== 1'b1) ok = 1'b0;
            rxQ.push_back(b);
            rxStart.push_back(st);
            if (!ok) frameErrs++;
         end
      end
   end

   task automatic push(input logic [7:0] b);
      bit done = 1'b0;
      bit rdy;
      for (int k = 0; k < 20000 && !done; k++) begin
         @(negedge clk_s);
         iDATA  = b;
         iVALID = 1'b1;
         rdy    = oREADY;
         @(posedge clk_s);
         if (rdy) done = 1'b1;
      end
      check($sformatf("pushAccepted %0h", b), done, 1);
   endtask

   task automatic clearRx();
      rxQ.delete();
      rxStart.delete();
      frameErrs = 0;
   endtask

   // Called on the negedge where the start bit is first visible; walks the whole frame
   task automatic checkLine(input logic [7:0] b);
      logic        expBits [NBITS];
      int unsigned errs [NBITS];
      int          finIdx = -1;
      int unsigned finCnt = 0;
      int unsigned busyBad = 0;
      expBits[0] = 1'b0;
      for (int i = 0; i < 8; i++) expBits[i + 1] = b[i];
`ifdef UART_TX_PARITY_EN
      expBits[9] = ^b;
`endif
      expBits[NBITS - 1] = 1'b1;
      for (int i = 0; i < NBITS; i++) errs[i] = 0;
      for (int idx = 0; idx < int'(FRAME); idx++) begin
         if (idx > 0) @(negedge clk_s);
         if (oTXDATA !== expBits[idx / CPB]) errs[idx / CPB]++;
         if (oFINISH === 1'b1) begin
            finCnt++;
            finIdx = idx;
         end
         if (idx == int'(FRAME) - 1) begin
            if (oBUSY !== 1'b0) busyBad++;
         end else if (oBUSY !== 1'b1) begin
            busyBad++;
         end
      end
      for (int i = 0; i < NBITS; i++) check($sformatf("line %0h bit%0d", b, i), errs[i], 0);
      check("finishCount", finCnt, 1);
      check("finishIndex", finIdx, FRAME - 2);
      check("busyProfile", busyBad, 0);
      @(negedge clk_s);
      check("lineIdleAfter", oTXDATA, 1);
   endtask

   initial begin
      int unsigned bad;
      bit found;

      // Reset and idle
      repeat (3) @(negedge clk_s);
      check("rst tx", oTXDATA, 1);
      check("rst busy", oBUSY, 0);
      check("rst ready", oREADY, 1);
      check("rst level", oLEVEL, 0);
      check("rst finish", oFINISH, 0);
      rst_s = 1'b0;
      bad = 0;
      repeat (1000) begin
         @(negedge clk_s);
         if (oTXDATA !== 1'b1 || oBUSY !== 1'b0 || oREADY !== 1'b1 || oLEVEL !== 5'd0) bad++;
      end
      check("idle1000", bad, 0);

      // Single byte 0xA5: latency and line shape
      clearRx();
      push(8'hA5);
      @(negedge clk_s);
      iVALID = 1'b0;
      check("lat1 tx", oTXDATA, 1);
      check("lat1 busy", oBUSY, 0);
      check("lat1 level", oLEVEL, 1);
      @(negedge clk_s);
      check("lat2 tx", oTXDATA, 1);
      check("lat2 busy", oBUSY, 1);
      check("lat2 level", oLEVEL, 0);
      @(negedge clk_s);
      check("lat3 tx", oTXDATA, 0);
      checkLine(8'hA5);
      check("a5 decoded count", rxQ.size(), 1);
      if (rxQ.size() >= 1) check("a5 decoded", rxQ[0], 8'hA5);

      // Burst 0x00..0x10 with iVALID held high
      clearRx();
      for (int i = 0; i <= 16; i++) push(8'(i));
      @(negedge clk_s);
      iVALID = 1'b0;
      check("burst ready", oREADY, 0);
      check("burst level", oLEVEL, 16);
      for (int k = 0; k < int'(17 * FRAME + 3000) && rxQ.size() < 17; k++) @(negedge clk_s);
      check("burst frames", rxQ.size(), 17);
      for (int i = 0; i < 17 && i < rxQ.size(); i++) begin
         check($sformatf("burst byte%0d", i), rxQ[i], i);
         if (i > 0) check($sformatf("burst gap%0d", i), rxStart[i] - rxStart[i - 1], FRAME);
      end
      check("burst frameErrs", frameErrs, 0);
      repeat (500) @(negedge clk_s);
      check("burst idle busy", oBUSY, 0);

      // Push on the same edge as the STOP-end pop
      clearRx();
      push(8'h5A);
      push(8'hC3);
      @(negedge clk_s);
      iVALID = 1'b0;
      check("pp level pre", oLEVEL, 1);
      found = 1'b0;
      for (int k = 0; k < int'(FRAME + 100); k++) begin
         if (oFINISH === 1'b1) begin
            found = 1'b1;
            break;
         end
         @(negedge clk_s);
      end
      check("pp finish seen", found, 1);
      check("pp level at finish", oLEVEL, 1);
      iDATA  = 8'h96;
      iVALID = 1'b1;
      @(posedge clk_s);
      @(negedge clk_s);
      iVALID = 1'b0;
      check("pp level after", oLEVEL, 1);
      check("pp busy after", oBUSY, 1);
      for (int k = 0; k < int'(3 * FRAME); k++) begin
         if (rxQ.size() >= 3) break;
         @(negedge clk_s);
      end
      repeat (5000) @(negedge clk_s);
      check("pp frames", rxQ.size(), 3);
      if (rxQ.size() >= 3) begin
         check("pp byte0", rxQ[0], 8'h5A);
         check("pp byte1", rxQ[1], 8'hC3);
         check("pp byte2", rxQ[2], 8'h96);
         check("pp gap1", rxStart[1] - rxStart[0], FRAME);
         check("pp gap2", rxStart[2] - rxStart[1], FRAME);
      end
      check("pp frameErrs", frameErrs, 0);

      // Reset mid-DATA of 0x3C with three bytes queued
      clearRx();
      push(8'h3C);
      push(8'h11);
      push(8'h22);
      push(8'h33);
      @(negedge clk_s);
      iVALID = 1'b0;
      repeat (CPB * 3) @(negedge clk_s);
      check("mid busy", oBUSY, 1);
      check("mid level", oLEVEL, 3);
      rst_s = 1'b1;
      @(negedge clk_s);
      check("abort tx", oTXDATA, 1);
      check("abort level", oLEVEL, 0);
      check("abort busy", oBUSY, 0);
      check("abort ready", oREADY, 1);
      rst_s = 1'b0;
      bad = 0;
      repeat (2 * FRAME) begin
         @(negedge clk_s);
         if (oTXDATA !== 1'b1 || oBUSY !== 1'b0 || oLEVEL !== 5'd0) bad++;
      end
      check("abort quiet", bad, 0);

      // 0x07 (parity bit 1 when parity is enabled)
      clearRx();
      push(8'h07);
      @(negedge clk_s);
      iVALID = 1'b0;
      @(negedge clk_s);
      @(negedge clk_s);
      check("b07 start", oTXDATA, 0);
      checkLine(8'h07);
      check("b07 decoded count", rxQ.size(), 1);
      if (rxQ.size() >= 1) check("b07 decoded", rxQ[0], 8'h07);
      check("b07 frameErrs", frameErrs, 0);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
